// File: rtl/pwm_bank_if.sv
// rtl/pwm_bank_if.sv - control and output bundle of the PWM dimmer bank
interface pwm_bank_if #(
    parameter int N_CH = 8,
    parameter int CH_W = 3
);
    logic [CH_W-1:0] ch_sel;
    logic            inc;
    logic            dec;
    logic            mode_tgl;
    logic [N_CH-1:0] pwm_out;
    logic [6:0]      sel_duty;
    logic            mode;
    logic            period_start;

    modport master (
        output ch_sel, inc, dec, mode_tgl,
        input  pwm_out, sel_duty, mode, period_start
    );

    modport slave (
        input  ch_sel, inc, dec, mode_tgl,
        output pwm_out, sel_duty, mode, period_start
    );
endinterface

// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - N-channel PWM dimmer with shadowed duties and two rates (option: PWM_PHASE_STAGGER_EN)
module pwm_bank #(
    parameter int N_CH      = 8,
    parameter int CH_W      = 3,
    parameter int PRE_W     = 16,
    parameter int PRE_SLOW  = 20000,
    parameter int PRE_FAST  = 5000,
    parameter int DUTY_STEP = 5,
    parameter int DUTY_RST  = 50
) (
    input  logic       clk,
    input  logic       reset,
    pwm_bank_if.slave  bus
);

    localparam logic [PRE_W-1:0] PRE_SLOW_MAX = PRE_W'(PRE_SLOW - 1);
    localparam logic [PRE_W-1:0] PRE_FAST_MAX = PRE_W'(PRE_FAST - 1);
    localparam logic [7:0]       STEP         = 8'(DUTY_STEP);
    localparam logic [6:0]       RST_DUTY     = 7'(DUTY_RST);

    logic [PRE_W-1:0] pre_cnt;
    logic [6:0]       phase;
    logic             primed;
    logic             mode_q;
    logic             ps_q;
    logic [N_CH-1:0]  pwm_q;
    logic [6:0]       active     [N_CH];
    logic [6:0]       shadow     [N_CH];
    logic [6:0]       active_nxt [N_CH];
    logic [7:0]       ph_i       [N_CH];

    logic [CH_W-1:0]  ch;
    logic [PRE_W-1:0] pre_max;
    logic             pre_wrap;
    logic             period_wrap;
    logic             restart;
    logic             step_req;

    function automatic logic [6:0] duty_up(input logic [6:0] d);
        logic [7:0] s;
        s = {1'b0, d} + STEP;
        return (s > 8'd100) ? 7'd100 : s[6:0];
    endfunction

    function automatic logic [6:0] duty_down(input logic [6:0] d);
        logic [7:0] s;
        s = ({1'b0, d} < STEP) ? 8'd0 : ({1'b0, d} - STEP);
        return s[6:0];
    endfunction

    assign ch = bus.ch_sel;

    // Rate selection and wrap detection; the first cycle after reset restarts the period like a mode toggle.
    always_comb begin
        pre_max     = mode_q ? PRE_FAST_MAX : PRE_SLOW_MAX;
        pre_wrap    = (pre_cnt == pre_max);
        period_wrap = pre_wrap && (phase == 7'd99);
        restart     = bus.mode_tgl || !primed;
        step_req    = bus.inc ^ bus.dec;
    end

    // Saturating inc/dec of the selected channel; simultaneous inc and dec cancel, out-of-range ch_sel matches nothing.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            active_nxt[i] = active[i];
            if (step_req && (int'(ch) == i)) begin
                active_nxt[i] = bus.inc ? duty_up(active[i]) : duty_down(active[i]);
            end
        end
    end

    // Duty readback of the selected channel, 0 when ch_sel names no channel.
    always_comb begin
        bus.sel_duty = 7'd0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(ch) == i) bus.sel_duty = active[i];
        end
    end

    // Per-channel phase, optionally offset so channel edges do not all switch together.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
`ifdef PWM_PHASE_STAGGER_EN
            ph_i[i] = {1'b0, phase} + 8'(i * (100 / N_CH));
            if (ph_i[i] >= 8'd100) ph_i[i] = ph_i[i] - 8'd100;
`else
            ph_i[i] = {1'b0, phase};
`endif
        end
    end

    // Prescaler, phase counter and period_start pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
            phase   <= 7'd0;
            ps_q    <= 1'b0;
            primed  <= 1'b0;
        end else if (restart) begin
            pre_cnt <= '0;
            phase   <= 7'd0;
            ps_q    <= 1'b1;
            primed  <= 1'b1;
        end else begin
            ps_q <= period_wrap;
            if (pre_wrap) begin
                pre_cnt <= '0;
                phase   <= (phase == 7'd99) ? 7'd0 : phase + 7'd1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    // Rate mode flips on each toggle pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mode_q <= 1'b0;
        else if (bus.mode_tgl) mode_q <= ~mode_q;
    end

    // Active duties take every update; shadows load only at period boundaries so outputs never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                active[i] <= RST_DUTY;
                shadow[i] <= RST_DUTY;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                active[i] <= active_nxt[i];
                if (restart) shadow[i] <= active_nxt[i];
                else if (period_wrap) shadow[i] <= active[i];
            end
        end
    end

    // Registered comparators: duty 0 never fires, duty 100 always fires since phase tops out at 99.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                pwm_q[i] <= (ph_i[i] < {1'b0, shadow[i]});
            end
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.mode         = mode_q;
    assign bus.period_start = ps_q;

endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - randomized check of pwm_bank against a period-time reference model
module tb_pwm_bank;

    localparam int NC = 6;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    pwm_bank_if #(.N_CH(NC), .CH_W(3)) bus ();

    pwm_bank #(
        .N_CH(NC), .CH_W(3), .PRE_W(16), .PRE_SLOW(4), .PRE_FAST(1),
        .DUTY_STEP(5), .DUTY_RST(50)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: time since period start, current duty, latched duty per channel.
    int m_t;
    int m_mode;
    int m_first;
    int m_ps;
    int m_duty [NC];
    int m_shad [NC];
    int m_pwm  [NC];

`ifdef PWM_PHASE_STAGGER_EN
    localparam int OFFS = 100 / NC;
`else
    localparam int OFFS = 0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int ticks_per_step(input int md);
        return (md != 0) ? 1 : 4;
    endfunction

    task automatic model_reset();
        m_t = 0; m_mode = 0; m_first = 1; m_ps = 0;
        for (int i = 0; i < NC; i++) begin
            m_duty[i] = 50; m_shad[i] = 50; m_pwm[i] = 0;
        end
    endtask

    task automatic model_step();
        int ph;
        int old [NC];
        int c;
        ph = m_t / ticks_per_step(m_mode);
        for (int i = 0; i < NC; i++) begin
            m_pwm[i] = (((ph + i * OFFS) % 100) < m_shad[i]) ? 1 : 0;
            old[i]   = m_duty[i];
        end
        c = int'(bus.ch_sel);
        if (c < NC && bus.inc !== bus.dec) begin
            if (bus.inc) m_duty[c] = (m_duty[c] + 5 > 100) ? 100 : m_duty[c] + 5;
            else         m_duty[c] = (m_duty[c] - 5 < 0)   ? 0   : m_duty[c] - 5;
        end
        if (bus.mode_tgl || m_first != 0) begin
            if (bus.mode_tgl) m_mode = 1 - m_mode;
            m_t = 0; m_ps = 1; m_first = 0;
            for (int i = 0; i < NC; i++) m_shad[i] = m_duty[i];
        end else begin
            m_t++;
            if (m_t == 100 * ticks_per_step(m_mode)) begin
                m_t = 0; m_ps = 1;
                for (int i = 0; i < NC; i++) m_shad[i] = old[i];
            end else begin
                m_ps = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [NC-1:0] ep;
        int c;
        for (int i = 0; i < NC; i++) ep[i] = (m_pwm[i] != 0);
        c = int'(bus.ch_sel);
        check_eq("pwm_out", 32'(bus.pwm_out), 32'(ep));
        check_eq("mode", 32'(bus.mode), 32'(m_mode));
        check_eq("period_start", 32'(bus.period_start), 32'(m_ps));
        check_eq("sel_duty", 32'(bus.sel_duty), (c < NC) ? 32'(m_duty[c]) : 32'd0);
    endtask

    // Called just after a falling edge: apply inputs, step model on the rising edge, compare 1 time unit later.
    task automatic drive(input int cs, input bit i_inc, input bit i_dec, input bit i_tgl);
        bus.ch_sel   = 3'(cs);
        bus.inc      = i_inc;
        bus.dec      = i_dec;
        bus.mode_tgl = i_tgl;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle(input int cs, input int n);
        for (int k = 0; k < n; k++) drive(cs, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic random_run(input int n);
        int r;
        for (int k = 0; k < n; k++) begin
            r = int'($urandom_range(0, 11));
            drive(int'($urandom_range(0, 7)), r < 3, (r >= 2) && (r < 5),
                  $urandom_range(0, 399) == 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset        = 1'b0;
        bus.ch_sel   = 3'd0;
        bus.inc      = 1'b0;
        bus.dec      = 1'b0;
        bus.mode_tgl = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_pwm", 32'(bus.pwm_out), 32'd0);
        check_eq("rst_mode", 32'(bus.mode), 32'd0);
        check_eq("rst_ps", 32'(bus.period_start), 32'd0);
        check_eq("rst_sel", 32'(bus.sel_duty), 32'd50);
        reset = 1'b1;

        // Default 50% pattern over two slow periods.
        idle(0, 900);

        // Saturate channel 2 upward, then downward.
        for (int k = 0; k < 11; k++) begin
            drive(2, 1'b1, 1'b0, 1'b0);
            idle(2, int'($urandom_range(0, 3)));
        end
        check_eq("sat_hi", 32'(bus.sel_duty), 32'd100);
        idle(2, 500);
        for (int k = 0; k < 20; k++) drive(2, 1'b0, 1'b1, 1'b0);
        check_eq("sat_lo", 32'(bus.sel_duty), 32'd0);
        drive(2, 1'b1, 1'b1, 1'b0);
        check_eq("inc_dec_same", 32'(bus.sel_duty), 32'd0);
        idle(2, 450);

        // Out-of-range channel selects.
        drive(6, 1'b1, 1'b0, 1'b0);
        check_eq("oob6_sel", 32'(bus.sel_duty), 32'd0);
        drive(7, 1'b1, 1'b0, 1'b0);
        check_eq("oob7_sel", 32'(bus.sel_duty), 32'd0);
        idle(0, 20);

        // Fast rate and back, toggled mid-period.
        drive(0, 1'b0, 1'b0, 1'b1);
        check_eq("tgl_mode", 32'(bus.mode), 32'd1);
        idle(0, 250);
        drive(3, 1'b1, 1'b0, 1'b1);
        check_eq("tgl_back", 32'(bus.mode), 32'd0);
        idle(0, 450);

        random_run(6000);

        // Asynchronous reset in the middle of a period.
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_eq("mid_rst_pwm", 32'(bus.pwm_out), 32'd0);
        check_eq("mid_rst_mode", 32'(bus.mode), 32'd0);
        check_eq("mid_rst_ps", 32'(bus.period_start), 32'd0);
        bus.inc = 1'b0; bus.dec = 1'b0; bus.mode_tgl = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(1, 450);
        random_run(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
